// File: rtl/tpu_pkg.sv
// Shared TPU definitions: default operand width, feeder FSM states, element type.
package tpu_pkg;
  localparam int unsigned TPU_BITS_AB = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } feeder_state_t;

  typedef logic signed [TPU_BITS_AB-1:0] elem_t;
endpackage

// File: rtl/tpu_operand_buf.sv
// DIM x DIM operand register file: one full-row write port, DIM diagonal read ports.
module tpu_operand_buf
  import tpu_pkg::*;
#(
  parameter int unsigned BITS_AB = TPU_BITS_AB,
  parameter int unsigned DIM     = 8,
  parameter int unsigned RW      = $clog2(DIM),
  parameter int unsigned CW      = $clog2(2*DIM-1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [RW-1:0]          wr_row,
  input  logic [DIM*BITS_AB-1:0] wr_data,
  input  logic [CW-1:0]          rd_cnt,
  output logic [DIM*BITS_AB-1:0] rd_diag
);

  logic [BITS_AB-1:0] mem [DIM][DIM];

  // Rows at or beyond DIM match no entry, so such writes fall away.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < DIM; r++)
        for (int unsigned k = 0; k < DIM; k++)
          mem[r][k] <= '0;
    end else if (wr_en) begin
      for (int unsigned r = 0; r < DIM; r++)
        if (wr_row == RW'(r))
          for (int unsigned k = 0; k < DIM; k++)
            mem[r][k] <= wr_data[k*BITS_AB +: BITS_AB];
    end
  end

  // Lane i reads column cnt-i; lanes outside their window read 0.
  always_comb begin
    rd_diag = '0;
    for (int unsigned i = 0; i < DIM; i++) begin
      if (32'(rd_cnt) >= i && (32'(rd_cnt) - i) < DIM)
        rd_diag[i*BITS_AB +: BITS_AB] = mem[i][RW'(32'(rd_cnt) - i)];
    end
  end

endmodule

// File: rtl/tpu_a_skew_feeder.sv
// A-operand feeder: buffers one tile and streams it into the array with diagonal skew.
module tpu_a_skew_feeder
  import tpu_pkg::*;
#(
  parameter int unsigned BITS_AB = TPU_BITS_AB,
  parameter int unsigned DIM     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load_vld,
  output logic                     load_rdy,
  input  logic [$clog2(DIM)-1:0]   load_row,
  input  logic [DIM*BITS_AB-1:0]   load_data,
  input  logic                     start,
  input  logic                     hold,
  output logic                     busy,
  output logic                     done,
  output logic                     arr_en,
  output logic [DIM*BITS_AB-1:0]   a_out
);

  localparam int unsigned RW = $clog2(DIM);
  localparam int unsigned CW = $clog2(2*DIM-1);
  localparam logic [CW-1:0] LAST = CW'(2*DIM-2);

  feeder_state_t          state;
  logic [CW-1:0]          cnt;
  logic [DIM*BITS_AB-1:0] diag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= STREAM;
            cnt   <= '0;
          end
        end
        STREAM: begin
          if (!hold) begin
            if (cnt == LAST) state <= DONE;
            else             cnt   <= cnt + CW'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign load_rdy = (state == IDLE);
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign arr_en   = (state == STREAM) && !hold;

  tpu_operand_buf #(
    .BITS_AB (BITS_AB),
    .DIM     (DIM),
    .RW      (RW),
    .CW      (CW)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (load_vld && load_rdy),
    .wr_row  (load_row),
    .wr_data (load_data),
    .rd_cnt  (cnt),
    .rd_diag (diag)
  );

  // Zero padding outside each lane's window and outside STREAM.
  always_comb begin
    a_out = '0;
    if (state == STREAM) begin
      for (int unsigned i = 0; i < DIM; i++) begin
        if (32'(cnt) >= i && (32'(cnt) - i) < DIM)
          a_out[i*BITS_AB +: BITS_AB] = diag[i*BITS_AB +: BITS_AB];
      end
    end
  end

endmodule
